// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port and a data port onto one single-port memory
// Ports: clk_i/rst_ni clock and async active-low reset;
//   if_req_i/if_addr_i -> if_rdata_o/if_ready_o   fetch read port;
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i -> dm_rdata_o/dm_ready_o   data port;
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o -> mem_rdata_i   memory side (MEM_LAT read latency);
//   stall_o   combinational: some request is pending without its ready.
module mem_arb #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [9:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e      state_q;
  logic [SW-1:0] starve_q;
  logic [2:0]  cnt_q;
  logic        gnt_dm_q;
  logic        wr_q;
  logic        gnt_dm;
  logic        unused_bits;
  // fetch only overrides a data request once it has lost STARVE_MAX times in a row
  assign gnt_dm = dm_req_i & ~(if_req_i & (starve_q == SMAX));
  assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);
  assign unused_bits = ^{if_addr_i[31:12], if_addr_i[1:0], dm_addr_i[31:12], dm_addr_i[1:0]};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      cnt_q       <= '0;
      gnt_dm_q    <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (if_req_i || dm_req_i) begin
          gnt_dm_q   <= gnt_dm;
          wr_q       <= gnt_dm & dm_we_i;
          mem_en_o   <= 1'b1;
          mem_we_o   <= gnt_dm & dm_we_i;
          mem_addr_o <= gnt_dm ? dm_addr_i[11:2] : if_addr_i[11:2];
          if (gnt_dm) mem_wdata_o <= dm_wdata_i;
          if (!gnt_dm) starve_q <= '0;
          else if (if_req_i && starve_q != SMAX) starve_q <= starve_q + 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          cnt_q    <= 3'(MEM_LAT);
          state_q  <= WAIT;
        end
        WAIT: if (cnt_q == 3'd1) begin
          if (!gnt_dm_q) if_rdata_o <= mem_rdata_i;
          else if (!wr_q) dm_rdata_o <= mem_rdata_i;
          if_ready_o <= ~gnt_dm_q;
          dm_ready_o <= gnt_dm_q;
          state_q    <= RESP;
        end else cnt_q <= cnt_q - 3'd1;
        RESP: begin
          if_ready_o <= 1'b0;
          dm_ready_o <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized self-checking bench for mem_arb against a behavioural memory/arbiter model
module tb_mem_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic if_ready1, dm_ready1, mem_en1, mem_we1, stall1;
  logic if_ready3, dm_ready3, mem_en3, mem_we3, stall3;
  logic [9:0] mem_addr1, mem_addr3;
  int checks = 0;
  int failures = 0;
  int en1_cnt = 0;

  mem_arb u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata1), .if_ready_o(if_ready1), .dm_req_i(dm_req), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata1), .dm_ready_o(dm_ready1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
    .mem_rdata_i(mem_rdata1), .stall_o(stall1)
  );

  mem_arb #(.MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata3), .if_ready_o(if_ready3), .dm_req_i(dm_req), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata3), .dm_ready_o(dm_ready3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
    .mem_rdata_i(mem_rdata3), .stall_o(stall3)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h2402_0005 : ((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000);
  endfunction

  // memory models: read data is valid only in the single cycle MEM_LAT after mem_en, junk otherwise
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  initial for (int i = 0; i < 1024; i++) begin
    mem1[i] <= init_word(i);
    mem3[i] <= init_word(i);
  end
  always @(posedge clk) begin
    if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
    if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    p1    <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : $urandom;
    p3[0] <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (mem_en1) en1_cnt <= en1_cnt + 1;
  end
  assign mem_rdata1 = p1;
  assign mem_rdata3 = p3[2];

  task automatic do_reset();
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output int ens, output bit both);
    int e0;
    @(negedge clk);
    e0 = en1_cnt;
    if (is_dm) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wd; end
    else begin if_req = 1; if_addr = addr; end
    lat = -1;
    both = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if_ready1 && dm_ready1) both = 1;
      if (is_dm ? dm_ready1 : if_ready1) begin lat = c; break; end
    end
    if_req = 0; dm_req = 0; dm_we = 0;
    ens = en1_cnt - e0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_rdata1, if_ready1, dm_rdata1, dm_ready1, mem_en1, mem_we1, mem_addr1, mem_wdata1, stall1} !== '0) begin
      failures++; $display("FAIL reset_dut1 got=%h exp=0", {if_rdata1, if_ready1, dm_rdata1, dm_ready1, mem_en1, mem_we1, mem_addr1, mem_wdata1, stall1});
    end
    checks++;
    if ({if_rdata3, if_ready3, dm_rdata3, dm_ready3, mem_en3, mem_we3, mem_addr3, mem_wdata3} !== '0) begin
      failures++; $display("FAIL reset_dut3 got=%h exp=0", {if_rdata3, if_ready3, dm_rdata3, dm_ready3, mem_en3, mem_we3, mem_addr3, mem_wdata3});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_en1, if_ready1, dm_ready1} !== 3'b000) begin
      failures++; $display("FAIL idle_no_req got=%b exp=000", {mem_en1, if_ready1, dm_ready1});
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0010;
    #1 checks++;
    if (stall1 !== 1'b1) begin failures++; $display("FAIL fetch_stall got=%b exp=1", stall1); end
    @(negedge clk);
    checks++;
    if ({mem_en1, mem_we1, mem_addr1, if_ready1} !== {1'b1, 1'b0, 10'd4, 1'b0}) begin
      failures++; $display("FAIL fetch_issue got=%b/%b/%h/%b exp=1/0/004/0", mem_en1, mem_we1, mem_addr1, if_ready1);
    end
    @(negedge clk);
    checks++;
    if ({mem_en1, if_ready1} !== 2'b00) begin
      failures++; $display("FAIL fetch_wait got=%b exp=00", {mem_en1, if_ready1});
    end
    @(negedge clk);
    checks++;
    if ({if_ready1, if_rdata1, dm_ready1, stall1} !== {1'b1, 32'h2402_0005, 1'b0, 1'b0}) begin
      failures++; $display("FAIL fetch_resp got=%b/%h/%b/%b exp=1/24020005/0/0", if_ready1, if_rdata1, dm_ready1, stall1);
    end
    if_req = 0;
    @(negedge clk);
    checks++;
    if ({if_ready1, if_rdata1} !== {1'b0, 32'h2402_0005}) begin
      failures++; $display("FAIL fetch_hold got=%b/%h exp=0/24020005", if_ready1, if_rdata1);
    end
  endtask

  task automatic test_store();
    int lat, ens, pulses;
    bit both;
    logic [31:0] old;
    run_txn(1, 0, 32'h0000_001C, 0, lat, ens, both);
    checks++;
    if ({lat, dm_rdata1} !== {32'sd3, ref_mem[7]}) begin
      failures++; $display("FAIL load_before_store got=%0d/%h exp=3/%h", lat, dm_rdata1, ref_mem[7]);
    end
    old = dm_rdata1;
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0FFC; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_en1, mem_we1, mem_addr1, mem_wdata1} !== {1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL store_issue got=%b/%b/%h/%h exp=1/1/3ff/deadbeef", mem_en1, mem_we1, mem_addr1, mem_wdata1);
    end
    pulses = 0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (dm_ready1) begin pulses++; dm_req = 0; dm_we = 0; end
    end
    ref_mem[10'h3FF] = 32'hDEAD_BEEF;
    checks++;
    if ({pulses, dm_rdata1} !== {32'sd1, old}) begin
      failures++; $display("FAIL store_resp got=%0d/%h exp=1/%h", pulses, dm_rdata1, old);
    end
  endtask

  task automatic test_random();
    int lat, ens;
    bit both, is_dm, we;
    logic [9:0] w;
    logic [31:0] wd, got, prev_dm;
    for (int n = 0; n < 30; n++) begin
      is_dm = 1'($urandom);
      we = is_dm & 1'($urandom);
      w = 10'($urandom_range(0, 511));
      wd = $urandom;
      prev_dm = dm_rdata1;
      run_txn(is_dm, we, {20'($urandom), w, 2'($urandom)}, wd, lat, ens, both);
      checks++;
      if ({lat, ens, both} !== {32'sd3, 32'sd1, 1'b0}) begin
        failures++; $display("FAIL rand_timing n=%0d got lat=%0d ens=%0d both=%b exp 3/1/0", n, lat, ens, both);
      end
      got = is_dm ? dm_rdata1 : if_rdata1;
      if (we) ref_mem[w] = wd;
      checks++;
      if (got !== (we ? prev_dm : ref_mem[w])) begin
        failures++; $display("FAIL rand_data n=%0d dm=%b we=%b got=%h exp=%h", n, is_dm, we, got, we ? prev_dm : ref_mem[w]);
      end
    end
  endtask

  task automatic test_starve();
    bit seq [$];
    bit exp_dm;
    int run;
    do_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0040; dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0080;
    for (int c = 0; c < 60 && seq.size() < 10; c++) begin
      @(negedge clk);
      checks++;
      if (if_ready1 && dm_ready1) begin failures++; $display("FAIL both_ready cycle=%0d", c); end
      if (if_ready1) seq.push_back(1'b0);
      if (dm_ready1) seq.push_back(1'b1);
    end
    if_req = 0; dm_req = 0;
    checks++;
    if (seq.size() != 10) begin failures++; $display("FAIL starve_count got=%0d exp=10", seq.size()); end
    run = 0;
    foreach (seq[k]) begin
      exp_dm = (run != 4);
      run = exp_dm ? run + 1 : 0;
      checks++;
      if (seq[k] !== exp_dm) begin failures++; $display("FAIL starve_seq k=%0d got_dm=%b exp_dm=%b", k, seq[k], exp_dm); end
    end
    checks++;
    if ({if_rdata1, dm_rdata1} !== {ref_mem[16], ref_mem[32]}) begin
      failures++; $display("FAIL starve_data got=%h/%h exp=%h/%h", if_rdata1, dm_rdata1, ref_mem[16], ref_mem[32]);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_lat3();
    int lat, en_at;
    do_reset();
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 32'(1000 * 4);
    lat = -1; en_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_en3 && en_at < 0) en_at = c;
      if (dm_ready3) begin lat = c; break; end
    end
    dm_req = 0;
    checks++;
    if ({en_at, lat} !== {32'sd1, 32'sd5}) begin
      failures++; $display("FAIL lat3_timing got en=%0d ready=%0d exp en=1 ready=5", en_at, lat);
    end
    checks++;
    if (dm_rdata3 !== init_word(1000)) begin
      failures++; $display("FAIL lat3_data got=%h exp=%h", dm_rdata3, init_word(1000));
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses, lat;
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 32'(20 * 4);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1 checks++;
    if ({if_rdata1, if_ready1, dm_rdata1, dm_ready1, mem_en1, mem_we1, mem_addr1, mem_wdata1} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got=%h exp=0", {if_rdata1, if_ready1, dm_rdata1, dm_ready1, mem_en1, mem_we1, mem_addr1, mem_wdata1});
    end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (dm_ready1 || if_ready1) pulses++; end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL reset_mid_ready got=%0d exp=0", pulses); end
    rst_n = 1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (dm_ready1) begin pulses++; if (lat < 0) lat = c; dm_req = 0; end
    end
    checks++;
    if ({pulses, lat, dm_rdata1} !== {32'sd1, 32'sd3, ref_mem[20]}) begin
      failures++; $display("FAIL reset_mid_rearb got pulses=%0d lat=%0d data=%h exp 1/3/%h", pulses, lat, dm_rdata1, ref_mem[20]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_drop();
    int pulses, lat, e0;
    @(negedge clk);
    e0 = en1_cnt;
    dm_req = 1; dm_we = 0; dm_addr = 32'(33 * 4);
    @(negedge clk);
    dm_req = 0;
    pulses = 0; lat = -1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (dm_ready1) begin pulses++; if (lat < 0) lat = c; end
    end
    checks++;
    if ({pulses, lat, dm_rdata1} !== {32'sd1, 32'sd3, ref_mem[33]}) begin
      failures++; $display("FAIL drop_resp got pulses=%0d lat=%0d data=%h exp 1/3/%h", pulses, lat, dm_rdata1, ref_mem[33]);
    end
    checks++;
    if (en1_cnt - e0 != 1) begin failures++; $display("FAIL drop_idle got mem_en=%0d exp=1", en1_cnt - e0); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch();
    test_store();
    test_random();
    test_starve();
    test_lat3();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from a memory issue cycle to mem_rdata valid; legal range 1..4.
REQ-002 Parameter STARVE_MAX, default 4: consecutive lost arbitrations after which the fetch port wins.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  fetch read request; held by requester until if_ready.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetch read data; holds last value until next fetch response.
REQ-008 if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req  input  1  data request; held until dm_ready.
REQ-010 dm_we  input  1  data write enable; 1 = store, 0 = load.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_rdata  output  32  load data; holds last value until next data read response.
REQ-014 dm_ready  output  1  one-cycle data completion pulse, for loads and stores.
REQ-015 mem_en  output  1  single-port memory access strobe, one cycle per access.
REQ-016 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-017 mem_addr  output  10  word address, equal to the granted address bits [11:2].
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-020 stall  output  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-022 In IDLE with any request pending, the block SHALL latch the grant (fetch or data) into registers, latch address, we and wdata into the mem_* output registers, and go to ISSUE; with no request pending it SHALL stay in IDLE.
REQ-023 Arbitration SHALL grant data over fetch when both request, except when starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-024 starve_cnt SHALL increment, saturating at STARVE_MAX, on each IDLE grant to data while if_req=1, and SHALL clear on each grant to fetch.
REQ-025 In ISSUE the block SHALL drive mem_en=1 for exactly one cycle, load cnt=MEM_LAT, and go to WAIT.
REQ-026 In WAIT, when cnt==1, the block SHALL capture mem_rdata into the granted port's rdata register (reads only) and go to RESP; otherwise it SHALL decrement cnt.
REQ-027 In RESP the block SHALL assert the granted port's ready for one cycle and go to IDLE.
REQ-028 Latency SHALL be as follows: a request first seen in IDLE at cycle T gets ready at cycle T+MEM_LAT+2 (T+3 for the default).
REQ-029 Stores SHALL NOT modify dm_rdata.
REQ-030 mem_en, mem_we and both ready outputs SHALL be 0 in every state other than the state named above for them; mem_we SHALL be 0 for fetch grants.
REQ-031 A request dropped mid-transaction SHALL NOT abort the transaction; the response still completes and ready still pulses.
REQ-032 Request inputs SHALL be sampled only in IDLE; changes in ISSUE, WAIT or RESP SHALL be ignored.
REQ-033 There SHALL be no more than one outstanding memory access, and if_ready and dm_ready SHALL never be high in the same cycle.

Reset
REQ-034 On rst=0 the block SHALL asynchronously enter IDLE and clear starve_cnt, cnt, the grant register, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready and dm_ready, all to 0.
REQ-035 Reset mid-transaction SHALL discard the access with no ready pulse; after release, a request still held SHALL be re-arbitrated from IDLE.

Verification
REQ-036 Fetch only, MEM_LAT=1, if_addr=0x0000_0010 at T, mem_rdata=0x2402_0005 -> mem_en=1 with mem_addr=4 at T+1; if_ready=1 and if_rdata=0x2402_0005 at T+3.
REQ-037 Store, dm_addr=0x0000_0FFC, dm_wdata=0xDEAD_BEEF -> one mem_en with mem_we=1, mem_addr=0x3FF, mem_wdata=0xDEAD_BEEF; dm_ready pulses once; dm_rdata unchanged.
REQ-038 if_req and dm_req both held continuously, dm re-requested after every dm_ready -> exactly 4 data grants, then 1 fetch grant, and the pattern repeats.
REQ-039 MEM_LAT=3 load -> ready exactly 5 cycles after the request is sampled; the data captured is the value present at ISSUE+3, not at ISSUE+2.
REQ-040 rst asserted during WAIT -> all outputs 0 immediately, no ready pulse; after release, with dm_req still held, one full access completes.
REQ-041 dm_req dropped in the cycle after ISSUE -> dm_ready still pulses once; the next IDLE cycle with no requests stays idle.
